wb_port_arbiter: RTL and testbench

Shares the single integer register-file write port between the integer pipeline's MEM/WB retirement and the FP pipeline's FEX/WB float-to-int conversion results. FP results enter a 2-entry skid FIFO so the FP pipeline retires without waiting. The integer side has default priority. A starvation counter forces an FP grant and back-pressures the integer pipeline. The write-port output stage is registered and also drives the simulation trace source tag.

---
 rtl/wb_port_arbiter_if.sv | 29 ++
 rtl/wb_port_arbiter.sv | 99 +++++++++
 tb/tb_wb_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-port arbiter bus: int/FP write requests in, register-file write out
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              int_valid;
    logic [IDX_W-1:0]  int_idx;
    logic [DATA_W-1:0] int_data;
    logic              int_ready;
    logic              fp_valid;
    logic [IDX_W-1:0]  fp_idx;
    logic [DATA_W-1:0] fp_data;
    logic              fp_ready;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_data;
    logic              rf_src;
    logic [1:0]        fp_pending;

    modport slave (
        input  int_valid, int_idx, int_data, fp_valid, fp_idx, fp_data,
        output int_ready, fp_ready, rf_we, rf_idx, rf_data, rf_src, fp_pending
    );

    modport master (
        output int_valid, int_idx, int_data, fp_valid, fp_idx, fp_data,
        input  int_ready, fp_ready, rf_we, rf_idx, rf_data, rf_src, fp_pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - integer/FP register-file write-port arbiter with FP skid FIFO and starvation guard
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [IDX_W-1:0]  idx_mem_q  [2];
    logic [DATA_W-1:0] data_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic              rf_we_q, rf_we_d;
    logic [IDX_W-1:0]  rf_idx_q, rf_idx_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              rf_src_q, rf_src_d;

    logic force_fp, int_gnt, fp_gnt, enq, fp_ready_w;

    // Ready depends only on registered occupancy: no enqueue at full even when draining.
    assign fp_ready_w = !rst && (cnt_q != 2'd2);
    assign force_fp   = (cnt_q != 2'd0) && (starve_q == STARVE_LIM);
    assign int_gnt    = bus.int_valid && !force_fp;
    assign fp_gnt     = !int_gnt && (cnt_q != 2'd0);
    assign enq        = bus.fp_valid && fp_ready_w;

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ enq;
        rd_ptr_d  = rd_ptr_q ^ fp_gnt;
        cnt_d     = cnt_q + {1'b0, enq} - {1'b0, fp_gnt};
        starve_d  = starve_q;
        if (fp_gnt || cnt_q == 2'd0) begin
            starve_d = '0;
        end else if (int_gnt && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        rf_we_d   = 1'b0;
        rf_idx_d  = rf_idx_q;
        rf_data_d = rf_data_q;
        rf_src_d  = rf_src_q;
        if (int_gnt) begin
            rf_we_d   = 1'b1;
            rf_idx_d  = bus.int_idx;
            rf_data_d = bus.int_data;
            rf_src_d  = 1'b0;
        end else if (fp_gnt) begin
            rf_we_d   = 1'b1;
            rf_idx_d  = idx_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
            rf_src_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
            rf_src_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_idx_q  <= rf_idx_d;
            rf_data_q <= rf_data_d;
            rf_src_q  <= rf_src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            idx_mem_q[wr_ptr_q]  <= bus.fp_idx;
            data_mem_q[wr_ptr_q] <= bus.fp_data;
        end
    end

    assign bus.int_ready  = !rst && !force_fp;
    assign bus.fp_ready   = fp_ready_w;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_idx     = rf_idx_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.rf_src     = rf_src_q;
    assign bus.fp_pending = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wb_port_arbiter_if #(.DATA_W(32), .IDX_W(5)) bus ();

    wb_port_arbiter #(.DATA_W(32), .IDX_W(5), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic int_drive(input logic v, input logic [4:0] idx, input logic [31:0] data);
        bus.int_valid = v;
        bus.int_idx   = idx;
        bus.int_data  = data;
    endtask

    task automatic fp_drive(input logic v, input logic [4:0] idx, input logic [31:0] data);
        bus.fp_valid = v;
        bus.fp_idx   = idx;
        bus.fp_data  = data;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] idx,
                            input logic [31:0] data, input logic src);
        check({tag, ".we"},   32'(bus.rf_we),  32'(we));
        check({tag, ".idx"},  32'(bus.rf_idx), 32'(idx));
        check({tag, ".data"}, bus.rf_data,     data);
        check({tag, ".src"},  32'(bus.rf_src), 32'(src));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        int_drive(1'b0, 5'd0, 32'h0);
        fp_drive(1'b0, 5'd0, 32'h0);
        tick();
        tick();

        // reset state
        check("rst.int_ready", 32'(bus.int_ready), 32'd0);
        check("rst.fp_ready",  32'(bus.fp_ready),  32'd0);
        check("rst.pending",   32'(bus.fp_pending), 32'd0);
        check_rf("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("idle.int_ready", 32'(bus.int_ready), 32'd1);
        check("idle.fp_ready",  32'(bus.fp_ready),  32'd1);

        // integer only, including index 0
        int_drive(1'b1, 5'd3, 32'h11);
        tick();
        check_rf("int1", 1'b1, 5'd3, 32'h11, 1'b0);
        check("int1.ready", 32'(bus.int_ready), 32'd1);
        int_drive(1'b1, 5'd4, 32'h22);
        tick();
        check_rf("int2", 1'b1, 5'd4, 32'h22, 1'b0);
        int_drive(1'b1, 5'd0, 32'h5A);
        tick();
        check_rf("int_idx0", 1'b1, 5'd0, 32'h5A, 1'b0);
        int_drive(1'b0, 5'd0, 32'h0);
        tick();
        check_rf("int_hold", 1'b0, 5'd0, 32'h5A, 1'b0);

        // FP only
        fp_drive(1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        fp_drive(1'b0, 5'd0, 32'h0);
        check("fp1.pending", 32'(bus.fp_pending), 32'd1);
        check("fp1.no_bypass", 32'(bus.rf_we), 32'd0);
        tick();
        check_rf("fp1", 1'b1, 5'd7, 32'hDEADBEEF, 1'b1);
        check("fp1.drained", 32'(bus.fp_pending), 32'd0);
        tick();
        check("fp1.idle_we", 32'(bus.rf_we), 32'd0);

        // starvation: one FP entry, integer side held busy
        int_drive(1'b1, 5'd1, 32'h100);
        fp_drive(1'b1, 5'd9, 32'hF0);
        tick();
        fp_drive(1'b0, 5'd0, 32'h0);
        check("stv.pending", 32'(bus.fp_pending), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stv.int_ready%0d", k), 32'(bus.int_ready), 32'd1);
            int_drive(1'b1, 5'd1, 32'h200 + 32'(k));
            tick();
            check_rf($sformatf("stv.int%0d", k), 1'b1, 5'd1, 32'h200 + 32'(k), 1'b0);
        end
        check("stv.forced", 32'(bus.int_ready), 32'd0);
        int_drive(1'b1, 5'd1, 32'h300);
        tick();
        check_rf("stv.fp", 1'b1, 5'd9, 32'hF0, 1'b1);
        check("stv.pending0", 32'(bus.fp_pending), 32'd0);
        check("stv.ready_back", 32'(bus.int_ready), 32'd1);
        tick();
        check_rf("stv.int_after", 1'b1, 5'd1, 32'h300, 1'b0);

        // FIFO full with integer side busy
        int_drive(1'b1, 5'd2, 32'h55);
        fp_drive(1'b1, 5'd10, 32'hA1);
        check("full.ready0", 32'(bus.fp_ready), 32'd1);
        tick();
        fp_drive(1'b1, 5'd11, 32'hA2);
        check("full.ready1", 32'(bus.fp_ready), 32'd1);
        tick();
        fp_drive(1'b1, 5'd12, 32'hA3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("full.pending%0d", k), 32'(bus.fp_pending), 32'd2);
            check($sformatf("full.blocked%0d", k), 32'(bus.fp_ready), 32'd0);
            tick();
            check($sformatf("full.int_src%0d", k), 32'(bus.rf_src), 32'd0);
        end
        check("full.forced", 32'(bus.int_ready), 32'd0);
        check("full.still_blocked", 32'(bus.fp_ready), 32'd0);
        tick();
        check_rf("full.fpA1", 1'b1, 5'd10, 32'hA1, 1'b1);
        check("full.pending_after", 32'(bus.fp_pending), 32'd1);
        check("full.ready_back", 32'(bus.fp_ready), 32'd1);
        tick();
        check_rf("full.int_again", 1'b1, 5'd2, 32'h55, 1'b0);
        check("full.pending_A3", 32'(bus.fp_pending), 32'd2);
        int_drive(1'b0, 5'd0, 32'h0);
        fp_drive(1'b0, 5'd0, 32'h0);
        tick();
        check_rf("full.fpA2", 1'b1, 5'd11, 32'hA2, 1'b1);
        tick();
        check_rf("full.fpA3", 1'b1, 5'd12, 32'hA3, 1'b1);
        check("full.empty", 32'(bus.fp_pending), 32'd0);
        tick();

        // reset mid-operation: pending 2, starve 3, rf_we 1
        int_drive(1'b1, 5'd6, 32'h66);
        fp_drive(1'b1, 5'd13, 32'hB1);
        tick();
        fp_drive(1'b1, 5'd14, 32'hB2);
        tick();
        tick();
        tick();
        check("mid.pending", 32'(bus.fp_pending), 32'd2);
        check("mid.we", 32'(bus.rf_we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.rst_int_ready", 32'(bus.int_ready), 32'd0);
        check("mid.rst_fp_ready",  32'(bus.fp_ready),  32'd0);
        tick();
        check_rf("mid.rst", 1'b0, 5'd0, 32'h0, 1'b0);
        check("mid.rst_pending", 32'(bus.fp_pending), 32'd0);
        rst = 1'b0;
        int_drive(1'b0, 5'd0, 32'h0);
        fp_drive(1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid.no_stale%0d", k), 32'(bus.rf_we), 32'd0);
            check($sformatf("mid.pending%0d", k), 32'(bus.fp_pending), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
